// File: rtl/countdown_ctrl_pkg.sv
// Shared types and defaults for the countdown control stage.
// State encoding matches the debug/display decode downstream.
package countdown_ctrl_pkg;

   localparam int CTRL_STATE_BIT_WIDTH = 2;

   typedef enum logic [CTRL_STATE_BIT_WIDTH-1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_e;

   localparam logic [19:0] DB_CYCLES_DEF   = 20'd1000000;
   localparam logic [26:0] LONG_CYCLES_DEF = 27'd100000000;

endpackage

// File: rtl/countdown_ctrl_btn_cond.sv
// Push-button conditioning: 2-flop sync, debounce, one-pulse press,
// and a single long-press pulse per hold.
module countdown_ctrl_btn_cond
   import countdown_ctrl_pkg::*;
#(
   parameter logic [19:0] DB_CYCLES   = DB_CYCLES_DEF,
   parameter logic [26:0] LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_in,
   output logic o_press,
   output logic o_long
);

   logic        r_s1;
   logic        r_s2;
   logic        r_deb;
   logic        r_deb_q;
   logic [19:0] r_db_cnt;
   logic [26:0] r_long_cnt;
   logic        r_long_done;
   logic        w_long;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_deb    <= 1'b0;
         r_deb_q  <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_s1    <= i_in;
         r_s2    <= r_s1;
         r_deb_q <= r_deb;
         if (r_s2 == r_deb) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_CYCLES - 20'd1) begin
            r_deb    <= r_s2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 20'd1;
         end
      end
   end

   // Counter saturates; long_done keeps the pulse to one per hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_long_cnt  <= '0;
         r_long_done <= 1'b0;
      end else if (!r_deb) begin
         r_long_cnt  <= '0;
         r_long_done <= 1'b0;
      end else begin
         if (r_long_cnt != LONG_CYCLES - 27'd1)
            r_long_cnt <= r_long_cnt + 27'd1;
         if (w_long)
            r_long_done <= 1'b1;
      end
   end

   assign w_long  = r_deb && !r_long_done &&
                    (r_long_cnt == LONG_CYCLES - 27'd1);
   assign o_long  = w_long;
   assign o_press = r_deb && !r_deb_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/done controller driving the 2-digit down counter's
// enable and reload strobes; raises the alarm once the count hits 00.
module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter logic [19:0] DB_CYCLES   = DB_CYCLES_DEF,
   parameter logic [26:0] LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in,
   input  logic                            tick,
   input  logic                            zero,
   output logic                            count_enable,
   output logic                            load,
   output logic                            alarm,
   output logic [CTRL_STATE_BIT_WIDTH-1:0] state
);

   ctrl_state_e r_state;
   ctrl_state_e w_state_nxt;
   logic        r_load;
   logic        w_load_nxt;
   logic        r_alarm;
   logic        w_press;
   logic        w_long;
   logic        w_unused_tick;

   // tick is qualified with count_enable in the counter itself.
   assign w_unused_tick = tick;

   countdown_ctrl_btn_cond #(
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
   ) u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_in    (in),
      .o_press (w_press),
      .o_long  (w_long)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load_nxt  = 1'b0;
      if (w_long) begin
         w_state_nxt = ST_IDLE;
         w_load_nxt  = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: if (w_press) w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (zero)         w_state_nxt = ST_DONE;
               else if (w_press) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (w_press) w_state_nxt = ST_RUN;
            ST_DONE: begin
               if (w_press) begin
                  w_state_nxt = ST_IDLE;
                  w_load_nxt  = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_load  <= 1'b0;
         r_alarm <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_load  <= w_load_nxt;
         r_alarm <= (w_state_nxt == ST_DONE);
      end
   end

   // Gated directly by zero so 00 never decrements past itself.
   assign count_enable = (r_state == ST_RUN) && !zero;
   assign load         = r_load;
   assign alarm        = r_alarm;
   assign state        = r_state;

endmodule
